crc_16_check: RTL
=================

Name: crc_16_check

Overview:
- Receive-side Modbus RTU CRC-16 frame checker; the counterpart of the CRC generator on the response path.
- Sits between the UART byte receiver / 3.5-char silence detector and the frame parser.
- Accepts the frame byte stream and holds the last two bytes back in a delay line. Only the payload bytes go through the CRC engine, bit-serially, one bit per clock.
- At end of frame, compares the computed CRC with the received CRC (low byte first on the wire) and reports pass/fail plus the frame length.

Parameters:
- MAX_LEN, 256, maximum frame length in bytes, CRC bytes included; minimum legal value 4.
- CRC_POLY, 16'hA001, reflected CRC-16 polynomial.
- CRC_INIT, 16'hFFFF, CRC register value at the start of each frame.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- vi  in  1  byte valid strobe from the UART receiver
- di  in  8  received byte; sampled when vi && rdy
- eof  in  1  end-of-frame strobe from the silence detector, one cycle wide
- rdy  out  1  block can accept a byte this cycle
- valid  out  1  one-cycle result strobe
- ok  out  1  frame passed: CRC matched, no error flags set
- crc_calc  out  16  CRC computed over the payload
- crc_rx  out  16  received CRC, {last byte, second-last byte}
- len  out  $clog2(MAX_LEN+1)  frame length in bytes, CRC bytes included
- err_short  out  1  frame shorter than 4 bytes
- err_long  out  1  more than MAX_LEN bytes received
- err_ovr  out  1  vi arrived while rdy=0; the byte is lost

Behaviour:
- Reset values:
  - rdy=1; valid=0; ok=0; all error flags 0.
  - crc_calc=0, crc_rx=0, len=0.
  - Internal: CRC register = CRC_INIT; delay line empty; byte count 0; eof_pend=0; state IDLE.
- States:
  - IDLE: frame empty, rdy=1.
  - ACC: frame in progress, rdy=1.
  - SHIFT: bit processing, rdy=0.
  - CHECK: one cycle, drives the result.
- Byte accept (vi && rdy):
  - Byte count increments, saturating at MAX_LEN+1 (which sets err_long).
  - Byte enters a 2-byte delay line.
  - If the line already held 2 bytes, the oldest byte is XORed into the low 8 bits of the CRC register. The next state is SHIFT, so rdy=0 from the following cycle. Otherwise the next state is ACC.
- SHIFT: exactly 8 cycles, one bit per cycle.
  - If crc[0]=1: crc = (crc>>1) ^ CRC_POLY; otherwise crc = crc>>1.
  - After the 8th cycle: go to CHECK if eof_pend=1, else ACC.
  - Throughput: one byte per 9 cycles worst case.
- eof handling:
  - eof in ACC, or eof together with an accepted byte that needs no CRC work: CHECK on the next cycle.
  - eof during SHIFT, or together with a byte that starts SHIFT: sets eof_pend, and the check is deferred until SHIFT ends.
  - eof in IDLE (empty frame): ignored, no valid.
- CHECK:
  - valid=1 for one cycle.
  - crc_calc = CRC register; crc_rx = {delay[newest], delay[older]}; len = byte count.
  - err_short = count<4.
  - ok = (crc_calc==crc_rx) && !err_short && !err_long && !err_ovr.
  - Next cycle: CRC register = CRC_INIT, delay line emptied, count=0, eof_pend=0, state IDLE.
- Result outputs hold their values until the next valid; valid is the only pulse.
- Overrun: vi while rdy=0 drops the byte and sets a sticky internal flag. That flag is reported as err_ovr at the next CHECK and then cleared.
- err_long: once set, bytes are still accepted, but the CRC engine stops updating. The frame always fails.
- rst mid-SHIFT or mid-frame discards the frame entirely; no valid is emitted.
- vi and rst in the same cycle: rst wins.

Optional Feature:
- Macro: CRC_CHECK_STATS_EN.
- When defined:
  - Adds output good_cnt[15:0] and output bad_cnt[15:0], both saturating at 16'hFFFF and reset to 0.
  - On each valid, good_cnt increments if ok=1; otherwise bad_cnt increments.
  - Adds input cnt_clr: synchronous clear of both counters. If cnt_clr coincides with valid, the clear wins.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Good frame: bytes 01 03 00 00 00 01 84 0A, each as a 1-cycle vi with the next vi sent only when rdy=1, then eof -> valid=1, ok=1, crc_calc=16'h0A84, crc_rx=16'h0A84, len=8.
- Corrupted frame: same frame with byte 3 = 01 -> valid=1, ok=0, crc_calc!=16'h0A84, crc_rx=16'h0A84.
- Short frame: bytes 01 03 80, then eof -> valid=1, err_short=1, ok=0, len=3.
- Overrun: assert vi on the cycle after the third byte, while rdy=0 -> byte dropped; at eof err_ovr=1, ok=0. The next good frame passes with err_ovr=0.
- eof coincident with the final byte 0A of the good frame -> valid exactly 9 cycles after the byte is accepted, ok=1.
- rst asserted in the 4th SHIFT cycle, then the good frame is sent -> no valid from the aborted frame; the good frame gives ok=1, len=8.

Source files
------------

// File: rtl/crc_16_check_if.sv
// Byte-stream and result bundle for the Modbus RTU CRC-16 frame checker.
// Defining CRC_CHECK_STATS_EN adds the good/bad frame counters and their clear.
interface crc_16_check_if #(
    parameter int unsigned MAX_LEN = 256
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    logic             vi;
    logic [7:0]       di;
    logic             eof;
    logic             rdy;
    logic             valid;
    logic             ok;
    logic [15:0]      crc_calc;
    logic [15:0]      crc_rx;
    logic [LEN_W-1:0] len;
    logic             err_short;
    logic             err_long;
    logic             err_ovr;

`ifdef CRC_CHECK_STATS_EN
    logic             cnt_clr;
    logic [15:0]      good_cnt;
    logic [15:0]      bad_cnt;

    modport master (
        output vi, di, eof, cnt_clr,
        input  rdy, valid, ok, crc_calc, crc_rx, len,
               err_short, err_long, err_ovr, good_cnt, bad_cnt
    );

    modport slave (
        input  vi, di, eof, cnt_clr,
        output rdy, valid, ok, crc_calc, crc_rx, len,
               err_short, err_long, err_ovr, good_cnt, bad_cnt
    );
`else
    modport master (
        output vi, di, eof,
        input  rdy, valid, ok, crc_calc, crc_rx, len,
               err_short, err_long, err_ovr
    );

    modport slave (
        input  vi, di, eof,
        output rdy, valid, ok, crc_calc, crc_rx, len,
               err_short, err_long, err_ovr
    );
`endif
endinterface

// File: rtl/crc_16_check.sv
// Receive-side Modbus RTU CRC-16 frame checker with a 2-byte CRC delay line and bit-serial engine.
// Optional good/bad frame statistics are enabled by defining CRC_CHECK_STATS_EN.
module crc_16_check #(
    parameter int unsigned MAX_LEN  = 256,
    parameter logic [15:0] CRC_POLY = 16'hA001,
    parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
    input logic           clk,
    input logic           rst,
    crc_16_check_if.slave bus
);
    localparam int unsigned      CNT_W   = $clog2(MAX_LEN + 2);
    localparam int unsigned      LEN_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned      LEN_MAX = (1 << LEN_W) - 1;
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(4);

    typedef enum logic [1:0] {IDLE, ACC, SHIFT, CHECK} state_t;

    state_t           state;
    logic [15:0]      crc;
    logic [7:0]       dly_new;
    logic [7:0]       dly_old;
    logic [1:0]       dly_cnt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic             eof_pend;
    logic             ovr;

    logic             accept;
    logic [CNT_W-1:0] cnt_inc;
    logic             long_inc;
    logic [15:0]      crc_step;
    logic [15:0]      rx_word;
    logic             short_now;
    logic             long_now;
    logic             ovr_now;
    logic [LEN_W-1:0] len_now;

    always_comb begin
        accept    = bus.vi && (state == IDLE || state == ACC);
        cnt_inc   = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
        long_inc  = (cnt_inc == CNT_SAT);
        crc_step  = crc[0] ? ((crc >> 1) ^ CRC_POLY) : (crc >> 1);
        rx_word   = {dly_new, dly_old};
        short_now = (cnt < MIN_LEN);
        long_now  = (cnt == CNT_SAT);
        // a byte offered during CHECK is already lost, so it counts against this frame
        ovr_now   = ovr || bus.vi;
        len_now   = (32'(cnt) > LEN_MAX) ? '1 : LEN_W'(cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            crc           <= CRC_INIT;
            dly_new       <= '0;
            dly_old       <= '0;
            dly_cnt       <= '0;
            cnt           <= '0;
            bit_cnt       <= '0;
            eof_pend      <= 1'b0;
            ovr           <= 1'b0;
            bus.rdy       <= 1'b1;
            bus.valid     <= 1'b0;
            bus.ok        <= 1'b0;
            bus.crc_calc  <= '0;
            bus.crc_rx    <= '0;
            bus.len       <= '0;
            bus.err_short <= 1'b0;
            bus.err_long  <= 1'b0;
            bus.err_ovr   <= 1'b0;
        end else begin
            bus.valid <= 1'b0;
            unique case (state)
                IDLE, ACC: begin
                    if (accept) begin
                        cnt     <= cnt_inc;
                        dly_old <= dly_new;
                        dly_new <= bus.di;
                        // the byte leaving the delay line is payload; once too long the engine freezes
                        if (dly_cnt == 2'd2 && !long_inc) begin
                            crc      <= crc ^ {8'h00, dly_old};
                            bit_cnt  <= '0;
                            eof_pend <= bus.eof;
                            state    <= SHIFT;
                            bus.rdy  <= 1'b0;
                        end else begin
                            if (dly_cnt != 2'd2) begin
                                dly_cnt <= dly_cnt + 2'd1;
                            end
                            state   <= bus.eof ? CHECK : ACC;
                            bus.rdy <= !bus.eof;
                        end
                    end else if (bus.eof && state == ACC) begin
                        state   <= CHECK;
                        bus.rdy <= 1'b0;
                    end
                end
                SHIFT: begin
                    crc     <= crc_step;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bus.vi) begin
                        ovr <= 1'b1;
                    end
                    if (bus.eof) begin
                        eof_pend <= 1'b1;
                    end
                    if (bit_cnt == 3'd7) begin
                        state   <= (eof_pend || bus.eof) ? CHECK : ACC;
                        bus.rdy <= !(eof_pend || bus.eof);
                    end
                end
                CHECK: begin
                    bus.valid     <= 1'b1;
                    bus.ok        <= (crc == rx_word) && !short_now && !long_now && !ovr_now;
                    bus.crc_calc  <= crc;
                    bus.crc_rx    <= rx_word;
                    bus.len       <= len_now;
                    bus.err_short <= short_now;
                    bus.err_long  <= long_now;
                    bus.err_ovr   <= ovr_now;
                    crc           <= CRC_INIT;
                    dly_new       <= '0;
                    dly_old       <= '0;
                    dly_cnt       <= '0;
                    cnt           <= '0;
                    eof_pend      <= 1'b0;
                    ovr           <= 1'b0;
                    state         <= IDLE;
                    bus.rdy       <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    bus.rdy <= 1'b1;
                end
            endcase
        end
    end

`ifdef CRC_CHECK_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || bus.cnt_clr) begin
            bus.good_cnt <= '0;
            bus.bad_cnt  <= '0;
        end else if (bus.valid) begin
            if (bus.ok) begin
                if (bus.good_cnt != 16'hFFFF) begin
                    bus.good_cnt <= bus.good_cnt + 16'd1;
                end
            end else if (bus.bad_cnt != 16'hFFFF) begin
                bus.bad_cnt <= bus.bad_cnt + 16'd1;
            end
        end
    end
`endif
endmodule
